// File: rtl/z80_irq_pkg.sv
// Shared types and constants for the Z80 interrupt controller.
package z80_irq_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } irq_state_e;

   localparam logic [1:0] IM0 = 2'd0;
   localparam logic [1:0] IM1 = 2'd1;
   localparam logic [1:0] IM2 = 2'd2;

endpackage

// File: rtl/z80_sync_edge.sv
// Two-flop synchronizer for an active-low async pin, plus a falling-edge pulse
// derived from the synchronized level.
module z80_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic sync,
   output logic fall
);

   logic meta;
   logic prev;

   // Flops reset high so a pin held inactive never produces a spurious edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= 1'b1;
         sync <= 1'b1;
         prev <= 1'b1;
      end else begin
         meta <= din;
         sync <= meta;
         prev <= sync;
      end
   end

   assign fall = prev & ~sync;

endmodule

// File: rtl/z80_irq_ctrl.sv
// Z80 interrupt controller: IFF1/IFF2, IM mode, EI shadow, HALT tracking and
// the offer/acknowledge handshake with the instruction sequencer.
module z80_irq_ctrl
   import z80_irq_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       int_n,
   input  logic       nmi_n,
   input  logic       insn_done,
   input  logic       insn_ei,
   input  logic       insn_di,
   input  logic       insn_retn,
   input  logic       insn_halt,
   input  logic       insn_im,
   input  logic [1:0] insn_im_mode,
   input  logic       irq_ack,
   output logic       irq_take,
   output logic       irq_nmi,
   output logic [1:0] irq_mode,
   output logic       iff1,
   output logic       iff2,
   output logic       halted
);

   irq_state_e state, state_nxt;

   logic int_meta, int_sync;
   logic nmi_sync, nmi_fall;
   logic nmi_pending;
   logic ei_shadow;
   logic hit, hit_nmi;
   logic idle_done, ack_ok;
   logic mask_block, iff1_eff;

   z80_sync_edge u_nmi_sync (
      .clk   (clk),
      .reset (reset),
      .din   (nmi_n),
      .sync  (nmi_sync),
      .fall  (nmi_fall)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         int_meta <= 1'b1;
         int_sync <= 1'b1;
      end else begin
         int_meta <= int_n;
         int_sync <= int_meta;
      end
   end

   assign idle_done = (state == IDLE) && insn_done;
   assign ack_ok    = (state == OFFER) && irq_ack;

   // EI blocks its own boundary and the next; DI takes effect at its own.
   assign mask_block = ei_shadow | (insn_done & insn_ei);
   assign iff1_eff   = iff1 & ~(insn_done & insn_di);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      hit       = 1'b0;
      hit_nmi   = 1'b0;
      case (state)
         IDLE: begin
            if (insn_done || halted) begin
               if (nmi_pending) begin
                  hit     = 1'b1;
                  hit_nmi = 1'b1;
               end else if (!int_sync && iff1_eff && !mask_block) begin
                  hit = 1'b1;
               end
            end
            if (hit) state_nxt = OFFER;
         end
         OFFER: begin
            if (irq_ack) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign irq_take = (state == OFFER);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_nmi     <= 1'b0;
         irq_mode    <= IM0;
         iff1        <= 1'b0;
         iff2        <= 1'b0;
         halted      <= 1'b0;
         nmi_pending <= 1'b0;
         ei_shadow   <= 1'b0;
      end else begin
         if (hit) irq_nmi <= hit_nmi;

         // A fresh edge wins over a simultaneous NMI acknowledge.
         if (nmi_fall)                nmi_pending <= 1'b1;
         else if (ack_ok && irq_nmi)  nmi_pending <= 1'b0;

         if (idle_done) ei_shadow <= insn_ei;

         if (idle_done) begin
            if (insn_ei) begin
               iff1 <= 1'b1;
               iff2 <= 1'b1;
            end else if (insn_di) begin
               iff1 <= 1'b0;
               iff2 <= 1'b0;
            end else if (insn_retn) begin
               iff1 <= iff2;
            end
         end else if (ack_ok) begin
            if (irq_nmi) begin
               iff2 <= iff1;
               iff1 <= 1'b0;
            end else begin
               iff1 <= 1'b0;
               iff2 <= 1'b0;
            end
         end

         if (idle_done && insn_im && insn_im_mode != 2'd3) irq_mode <= insn_im_mode;

         if (idle_done && insn_halt) halted <= 1'b1;
         else if (ack_ok)            halted <= 1'b0;
      end
   end

endmodule

// File: doc/z80_irq_ctrl.md
Z80_IRQ_CTRL -- requirements
Module: z80_irq_ctrl

Interface
REQ-001 SHALL have: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: int_n  in  1  maskable interrupt, level, active-low, asynchronous.
REQ-004 SHALL have: nmi_n  in  1  non-maskable interrupt, falling-edge, asynchronous.
REQ-005 SHALL have: insn_done  in  1  one-cycle pulse, last cycle of an instruction (boundary).
REQ-006 SHALL have: insn_ei, insn_di, insn_retn, insn_halt  in  1 each  decoded class, valid only with insn_done.
REQ-007 SHALL have: insn_im  in  1 and insn_im_mode  in  2  IM n instruction and mode (0,1,2), valid with insn_done.
REQ-008 SHALL have: irq_ack  in  1  sequencer began service of the offered interrupt.
REQ-009 SHALL have: irq_take  out  1  interrupt offered to sequencer, held until irq_ack.
REQ-010 SHALL have: irq_nmi  out  1  offered interrupt is NMI (1) or maskable (0), stable while irq_take.
REQ-011 SHALL have: irq_mode  out  2  current IM, 3 never produced.
REQ-012 SHALL have: iff1, iff2  out  1 each  interrupt flip-flops; halted  out  1  CPU in HALT.

Function
REQ-013 int_n and nmi_n SHALL each pass a 2-FF synchronizer; sampled values lag the pins by 2 cycles.
REQ-014 A synchronized nmi_n 1->0 transition SHALL set nmi_pending; it SHALL clear only on irq_ack with irq_nmi=1.
REQ-015 States SHALL be IDLE and OFFER; IDLE->OFFER on a sample hit, OFFER->IDLE on irq_ack.
REQ-016 Sampling SHALL occur in IDLE on insn_done, and on every cycle while halted=1.
REQ-017 Sample priority: nmi_pending first (irq_nmi=1); else int sync low AND iff1=1 AND ei_shadow=0 (irq_nmi=0).
REQ-018 irq_take SHALL assert the cycle after the sample hit and remain 1 until the cycle after irq_ack.
REQ-019 EI at insn_done: iff1=iff2=1 and ei_shadow=1 on the next cycle; maskable sampling at this boundary is blocked.
REQ-020 ei_shadow SHALL clear at the next insn_done, where maskable sampling is still blocked; NMI ignores ei_shadow.
REQ-021 DI at insn_done: iff1=iff2=0 and ei_shadow=0 next cycle; maskable sampling at that boundary uses the new iff1=0.
REQ-022 RETN at insn_done: iff1<=iff2; IM n: irq_mode<=insn_im_mode (mode 3 input SHALL be ignored).
REQ-023 HALT at insn_done: halted=1 next cycle; halted SHALL clear on irq_ack.
REQ-024 irq_ack with irq_nmi=1: iff2<=iff1, iff1<=0; with irq_nmi=0: iff1=iff2=0.
REQ-025 irq_ack while IDLE SHALL be ignored; all insn_* inputs SHALL be ignored in OFFER.
REQ-026 An NMI edge arriving during an OFFER of a maskable interrupt SHALL stay pending and be offered at the next sample.

Reset
REQ-027 Reset SHALL force: state IDLE, irq_take=0, irq_nmi=0, irq_mode=0, iff1=iff2=0, halted=0, nmi_pending=0, ei_shadow=0, synchronizer FFs=1.
REQ-028 Reset asserted mid-OFFER SHALL drop irq_take immediately (asynchronously) and discard the pending NMI.

Structure
REQ-029 Package z80_irq_pkg SHALL hold the state enum (IDLE, OFFER) and IM0/IM1/IM2 constants.
REQ-030 One sub-module z80_sync_edge SHALL implement 2-FF sync plus falling-edge pulse; instantiated for nmi_n (int_n uses sync output only).

Verification
REQ-031 EI, then int_n low, insn_done x2 -> no irq_take until after second insn_done; irq_take on the cycle after the third insn_done boundary sample.
REQ-032 iff1=1, int_n low, DI with insn_done -> irq_take stays 0, iff1=iff2=0.
REQ-033 iff1=iff2=1, nmi_n falling edge, insn_done, irq_ack -> irq_nmi=1, after ack iff1=0, iff2=1; RETN -> iff1=1.
REQ-034 HALT, iff1=1, IM 2, int_n low with no insn_done -> irq_take within 3 cycles, irq_mode=2; irq_ack -> halted=0.
REQ-035 int_n low and nmi edge together at one boundary -> NMI offered first; after ack (iff1=0) maskable not offered.
REQ-036 Reset during OFFER -> irq_take=0 same cycle, all outputs at reset values, pending NMI lost.
